// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard / branch / memory-wait controller for a 5-stage pipe.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   branch_taken      EX-stage branch resolved taken
//   hazard            ID-stage RAW hazard
//   mem_req           MEM-stage load/store active
//   mem_ready         data memory completes the access this cycle
//   freeze_pc         hold the PC register
//   freeze_if         freeze IF/ID
//   flush_if          flush IF/ID
//   flush_id          bubble into ID/EX
//   freeze_mem        hold ID/EX, EX/MEM, MEM/WB
//   mem_err           sticky memory-timeout error
//   stall_cycles      saturating count of freeze_pc cycles
//   flush_count       saturating count of flush_if cycles
//
// Control outputs are combinational from state, inputs and the pending-branch
// flag; everything else is registered.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic        hazard,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        freeze_pc,
  output logic        freeze_if,
  output logic        flush_if,
  output logic        flush_id,
  output logic        freeze_mem,
  output logic        mem_err,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic        br_pend_q;
  logic        mem_err_q;
  logic [15:0] stall_q;
  logic [7:0]  flush_q;

  logic mem_stall;
  logic wait_done;
  logic branch_any;

  assign mem_stall  = mem_req & ~mem_ready;
  // A dropped request ends the wait just like a completed access.
  assign wait_done  = mem_ready | ~mem_req;
  assign branch_any = branch_taken | br_pend_q;

  // Control outputs
  always_comb begin
    freeze_pc  = 1'b0;
    freeze_if  = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    freeze_mem = 1'b0;
    unique case (state_q)
      RUN: begin
        // Priority: memory stall > branch > data hazard.
        if (mem_stall) begin
          freeze_pc  = 1'b1;
          freeze_if  = 1'b1;
          freeze_mem = 1'b1;
        end else if (branch_any) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (hazard) begin
          freeze_pc = 1'b1;
          freeze_if = 1'b1;
          flush_id  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!wait_done) begin
          freeze_pc  = 1'b1;
          freeze_if  = 1'b1;
          freeze_mem = 1'b1;
        end
      end
      ERROR: begin
        freeze_pc  = 1'b1;
        freeze_if  = 1'b1;
        freeze_mem = 1'b1;
      end
      default: ;
    endcase
  end

  // State, wait counter, pending branch, error flag and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      br_pend_q  <= 1'b0;
      mem_err_q  <= 1'b0;
      stall_q    <= 16'd0;
      flush_q    <= 8'd0;
    end else begin
      if (freeze_pc && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush_if  && flush_q != 8'hFF)    flush_q <= flush_q + 8'd1;

      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd1;
            // Branch resolved while memory stalls: remember it, flush later.
            if (branch_taken) br_pend_q <= 1'b1;
          end else if (branch_any) begin
            br_pend_q <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (branch_taken) br_pend_q <= 1'b1;
          if (wait_done) begin
            // Pending flush happens in the following RUN cycle.
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
          end else if (wait_cnt_q == TIMEOUT) begin
            state_q   <= ERROR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ERROR: mem_err_q <= 1'b1;  // only reset leaves ERROR
        default: state_q <= RUN;
      endcase
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// behavioural model of the controller's rules.
module tb_pipeline_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken, hazard, mem_req, mem_ready;
  logic        freeze_pc, freeze_if, flush_if, flush_id, freeze_mem, mem_err;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .hazard(hazard),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(freeze_pc), .freeze_if(freeze_if),
    .flush_if(flush_if), .flush_id(flush_id),
    .freeze_mem(freeze_mem), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: what the pipeline is doing, how long it has waited,
  // whether a branch still owes a flush, and the two event tallies.
  int  m_mode;    // 0 running, 1 waiting on memory, 2 dead (timeout)
  int  m_waited;  // memory-wait cycles seen so far in this episode
  bit  m_pend;
  bit  m_err;
  int  m_stalls;
  int  m_flushes;
  bit  e_fpc, e_fif, e_flif, e_flid, e_fmem;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_mode = 0; m_waited = 0; m_pend = 0; m_err = 0;
    m_stalls = 0; m_flushes = 0;
  endfunction

  function automatic void model_outputs();
    bit stuck;
    stuck = mem_req && !mem_ready;
    {e_fpc, e_fif, e_flif, e_flid, e_fmem} = 5'b0;
    if (m_mode == 2 || (m_mode == 1 && stuck)) begin
      e_fpc = 1; e_fif = 1; e_fmem = 1;
    end else if (m_mode == 0) begin
      if (stuck) begin
        e_fpc = 1; e_fif = 1; e_fmem = 1;
      end else if (branch_taken || m_pend) begin
        e_flif = 1; e_flid = 1;
      end else if (hazard) begin
        e_fpc = 1; e_fif = 1; e_flid = 1;
      end
    end
  endfunction

  function automatic void model_advance();
    bit stuck;
    stuck = mem_req && !mem_ready;
    if (e_fpc)  m_stalls  = (m_stalls  >= 65535) ? 65535 : m_stalls + 1;
    if (e_flif) m_flushes = (m_flushes >= 255)   ? 255   : m_flushes + 1;
    if (m_mode == 0) begin
      if (stuck) begin
        m_mode = 1; m_waited = 1;
        if (branch_taken) m_pend = 1;
      end else if (e_flif) begin
        m_pend = 0;
      end
    end else if (m_mode == 1) begin
      if (branch_taken) m_pend = 1;
      if (!stuck)                m_mode = 0;
      else if (m_waited >= TO) begin m_mode = 2; m_err = 1; end
      else                       m_waited++;
    end
  endfunction

  task automatic compare_all();
    model_outputs();
    chk("freeze_pc",    int'(freeze_pc),    int'(e_fpc));
    chk("freeze_if",    int'(freeze_if),    int'(e_fif));
    chk("flush_if",     int'(flush_if),     int'(e_flif));
    chk("flush_id",     int'(flush_id),     int'(e_flid));
    chk("freeze_mem",   int'(freeze_mem),   int'(e_fmem));
    chk("mem_err",      int'(mem_err),      int'(m_err));
    chk("stall_cycles", int'(stall_cycles), m_stalls);
    chk("flush_count",  int'(flush_count),  m_flushes);
  endtask

  // One clock cycle: drive at the falling edge, check, then let the model
  // take the coming rising edge.
  task automatic step(input bit b, input bit h, input bit q, input bit r);
    @(negedge clk);
    rst = 1'b0;
    branch_taken = b; hazard = h; mem_req = q; mem_ready = r;
    #1;
    compare_all();
    model_advance();
  endtask

  task automatic do_reset(input bit b, input bit h, input bit q, input bit r);
    @(negedge clk);
    rst = 1'b1;
    branch_taken = b; hazard = h; mem_req = q; mem_ready = r;
    #1;
    model_reset();
    compare_all();
  endtask

  initial begin
    rst = 1'b1;
    branch_taken = 0; hazard = 0; mem_req = 0; mem_ready = 0;
    do_reset(0, 0, 0, 0);
    chk("reset_stall0", int'(stall_cycles), 0);
    chk("reset_fpc0",   int'(freeze_pc), 0);

    // Single-cycle hazard
    step(0, 1, 0, 0);
    chk("hz_fpc", int'(freeze_pc), 1);
    chk("hz_fid", int'(flush_id), 1);
    chk("hz_fmem", int'(freeze_mem), 0);
    step(0, 0, 0, 0);
    chk("hz_stall1", int'(stall_cycles), 1);

    // Branch beats hazard
    step(1, 1, 0, 0);
    chk("br_flif", int'(flush_if), 1);
    chk("br_fpc", int'(freeze_pc), 0);
    step(0, 0, 0, 0);
    chk("br_count1", int'(flush_count), 1);

    // Three stalled cycles then completion
    do_reset(0, 0, 0, 0);
    repeat (3) begin
      step(0, 0, 1, 0);
      chk("mw_fmem", int'(freeze_mem), 1);
    end
    step(0, 0, 1, 1);
    chk("mw_exit_fpc", int'(freeze_pc), 0);
    step(0, 0, 0, 0);
    chk("mw_stall3", int'(stall_cycles), 3);

    // Deferred branch: flush lands one cycle after the wait ends
    do_reset(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("defer_exit_flif", int'(flush_if), 0);
    step(0, 0, 0, 0);
    chk("defer_flif", int'(flush_if), 1);
    chk("defer_flid", int'(flush_id), 1);
    step(0, 0, 0, 0);
    chk("defer_cleared", int'(flush_if), 0);

    // Timeout: entry cycle + TO waiting cycles, then stuck in error
    do_reset(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (TO) step(0, 0, 1, 0);
    chk("to_err_pre", int'(mem_err), 0);
    repeat (5) step(0, 0, 0, 0);
    chk("to_err", int'(mem_err), 1);
    chk("to_fpc", int'(freeze_pc), 1);
    do_reset(0, 0, 0, 0);
    chk("to_reset_err", int'(mem_err), 0);
    step(0, 0, 0, 0);
    chk("to_reset_run", int'(freeze_pc), 0);

    // Flush counter saturation
    do_reset(0, 0, 0, 0);
    repeat (300) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("flush_sat", int'(flush_count), 255);

    // Randomized traffic with occasional asynchronous resets
    do_reset(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit b, h, q, r;
      b = ($urandom_range(4) == 0);
      h = ($urandom_range(2) == 0);
      q = ($urandom_range(3) != 0);
      r = ($urandom_range(3) == 0);
      if ($urandom_range(32) == 0) do_reset(b, h, q, r);
      else                         step(b, h, q, r);
    end

    // Stall counter saturation
    do_reset(0, 0, 0, 0);
    repeat (70000) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("stall_sat", int'(stall_cycles), 65535);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
